gray_conv_pipe: RTL and testbench
=================================

Name: gray_conv_pipe

Overview:
Parametrised, pipelined Gray/binary code converter with a valid/ready handshake on both sides. Each accepted word carries a mode bit that selects Gray-to-binary (prefix XOR) or binary-to-Gray (shift XOR). The wide prefix-XOR chain is split across STAGES register stages so the block meets timing at large WIDTH. It sits on CDC pointer and encoder paths, where Gray-coded counters cross clock domains and are decoded after synchronisation.

Parameters:
WIDTH, 8, data word width in bits (>=2)
STAGES, 2, pipeline depth / latency in cycles (1..WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_mode  in  1  0 = Gray->binary, 1 = binary->Gray
in_data  in  WIDTH  input word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_mode  out  1  mode that travelled with the word
out_data  out  WIDTH  converted word
err_hd  out  1  sticky Hamming-distance error (see Optional Feature)

Behaviour:
- Reset (asynchronous assert on rst_n low, synchronous release): all stage valid bits 0, out_valid 0, out_data 0, out_mode 0, err_hd 0. in_ready is 1 on the first cycle after release.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Once out_valid is high it stays high, and out_data/out_mode stay stable, until the transfer completes.
- Pipeline: STAGES registered stages, each holding valid, mode, partial word and running XOR carry.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when it is empty or out_ready is high.
  - in_ready = stage 0 empty OR stage 0 advancing. Bubbles collapse.
  - Throughput is 1 word/cycle with out_ready held high.
- Latency: exactly STAGES cycles from input transfer to out_valid with no back-pressure.
- Gray->binary: B[WIDTH-1] = G[WIDTH-1]; B[i] = B[i+1] ^ G[i].
  - Chunk size C = ceil(WIDTH/STAGES). Stage k resolves bits [WIDTH-1-k*C -: C], clipped at bit 0.
  - The carry (last resolved B bit) passes to the next stage.
- Binary->Gray: G = B ^ (B >> 1), computed in stage 0. The result is carried unchanged through the remaining stages so latency is uniform for both modes.
- Modes may alternate on consecutive words with no bubble. Order is strictly preserved.
- Simultaneous input and output transfer while full: accepted, and occupancy is unchanged.
- Reset mid-operation: all in-flight words are discarded and none appear after release.
- STAGES = WIDTH: one bit resolved per stage. STAGES = 1: single registered stage, fully combinational conversion.

Optional Feature:
Macro GRAY_CONV_HD_CHK_EN.
- With macro: the block tracks the last accepted in_data of mode 0 (Gray). A subsequent mode-0 input transfer whose Hamming distance from it is not 0 or 1 sets err_hd.
  - err_hd rises the cycle after the offending transfer and stays set until rst_n.
  - The first mode-0 word after reset is never flagged.
  - Mode-1 words are ignored by the checker.
- Without macro: no tracking logic is built, and err_hd is tied to constant 0.

Decomposition:
- Shared package gray_pkg: mode encoding constants (MODE_G2B = 1'b0, MODE_B2G = 1'b1), a chunk-size constant function ceil_div, and a stage-payload struct typedef (valid, mode, data, carry).
- One natural sub-module: gray_conv_stage, a single pipeline stage parametrised by chunk position. It holds the payload register and per-stage advance logic and is instantiated STAGES times via generate.

Test Plan:
- WIDTH=8, STAGES=2, mode 0, in_data 0xC3, out_ready=1 -> out_data 0x82, out_mode 0, out_valid exactly 2 cycles after accept.
- Mode 1, in_data 0x82 -> out_data 0xC3 after 2 cycles; mode 0 with 0x80 -> 0xFF.
- Back-to-back stream of 0x00..0xFF alternating modes, out_ready=1 -> one output per cycle, in order, each matching the reference function; in_ready never drops.
- Hold out_ready=0 for 5 cycles while streaming -> in_ready falls after 2 accepted words, out_data is stable while stalled, no loss or duplication on release.
- Assert rst_n low mid-stream with 2 words in flight -> out_valid 0 immediately; after release, no stale word emerges.
- With GRAY_CONV_HD_CHK_EN: mode-0 sequence 0x00, 0x01, 0x03, 0x00 -> err_hd 0 through 0x03, then 1 the cycle after 0x00 is accepted, held until reset. Without the macro -> err_hd stays 0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the pipelined Gray/binary converter: mode encoding,
// chunk sizing helper and the per-stage control payload.
package gray_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Data travels beside this struct because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic mode;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/gray_conv_stage.sv
// One register stage of the converter. In Gray->binary mode it resolves the
// bits [HI:LO] of its chunk; binary->Gray is done entirely in stage 0.
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGE_IDX = 0,
  parameter int CHUNK     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic             up_carry,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic             mode,
  output logic             carry,
  output logic [WIDTH-1:0] data
);

  localparam int HI = WIDTH - 1 - STAGE_IDX * CHUNK;
  localparam int LO = (HI - CHUNK + 1 < 0) ? 0 : HI - CHUNK + 1;

  stage_ctrl_t      ctrl_q, ctrl_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] conv_data;
  logic             conv_carry;

  // Stages beyond the word (HI < 0) simply pass their payload along.
  always_comb begin
    conv_data  = up_data;
    conv_carry = up_carry;
    if (up_mode == MODE_G2B) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i <= HI && i >= LO) begin
          conv_carry   = conv_carry ^ up_data[i];
          conv_data[i] = conv_carry;
        end
      end
    end else if (STAGE_IDX == 0) begin
      conv_data = up_data ^ (up_data >> 1);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (advance) begin
      ctrl_d.valid = up_valid;
      if (up_valid) begin
        ctrl_d.mode  = up_mode;
        ctrl_d.carry = conv_carry;
        data_d       = conv_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign valid = ctrl_q.valid;
  assign mode  = ctrl_q.mode;
  assign carry = ctrl_q.carry;
  assign data  = data_q;

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready on both sides.
// Define GRAY_CONV_HD_CHK_EN to build the sticky Hamming-distance checker.
module gray_conv_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             err_hd
);

  localparam int CHUNK = ceil_div(WIDTH, STAGES);

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_mode;
  logic [STAGES-1:0] st_carry;
  logic [WIDTH-1:0]  st_data [STAGES];
  logic [STAGES:0]   ready_chain;
  logic              carry_unused;

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    ready_chain         = '0;
    ready_chain[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready_chain[k] = !st_valid[k] || ready_chain[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      gray_conv_stage #(.WIDTH(WIDTH), .STAGE_IDX(k), .CHUNK(CHUNK)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (ready_chain[k]),
        .up_valid (in_valid),
        .up_mode  (in_mode),
        .up_carry (1'b0),
        .up_data  (in_data),
        .valid    (st_valid[k]),
        .mode     (st_mode[k]),
        .carry    (st_carry[k]),
        .data     (st_data[k])
      );
    end else begin : g_next
      gray_conv_stage #(.WIDTH(WIDTH), .STAGE_IDX(k), .CHUNK(CHUNK)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (ready_chain[k]),
        .up_valid (st_valid[k-1]),
        .up_mode  (st_mode[k-1]),
        .up_carry (st_carry[k-1]),
        .up_data  (st_data[k-1]),
        .valid    (st_valid[k]),
        .mode     (st_mode[k]),
        .carry    (st_carry[k]),
        .data     (st_data[k])
      );
    end
  end

  assign in_ready     = ready_chain[0];
  assign out_valid    = st_valid[STAGES-1];
  assign out_mode     = st_mode[STAGES-1];
  assign out_data     = st_data[STAGES-1];
  assign carry_unused = st_carry[STAGES-1];

`ifdef GRAY_CONV_HD_CHK_EN
  logic [WIDTH-1:0] last_gray_q, last_gray_d;
  logic             have_gray_q, have_gray_d;
  logic             err_hd_q, err_hd_d;

  // Consecutive Gray-coded inputs may differ in at most one bit.
  always_comb begin
    last_gray_d = last_gray_q;
    have_gray_d = have_gray_q;
    err_hd_d    = err_hd_q;
    if (in_valid && in_ready && in_mode == MODE_G2B) begin
      if (have_gray_q && $countones(in_data ^ last_gray_q) > 1) begin
        err_hd_d = 1'b1;
      end
      last_gray_d = in_data;
      have_gray_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gray_q <= '0;
      have_gray_q <= 1'b0;
      err_hd_q    <= 1'b0;
    end else begin
      last_gray_q <= last_gray_d;
      have_gray_q <= have_gray_d;
      err_hd_q    <= err_hd_d;
    end
  end

  assign err_hd = err_hd_q;
`else
  assign err_hd = 1'b0;
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Self-checking bench for gray_conv_pipe: directed vectors plus random traffic
// checked against a queue-based reference model.
module tb_gray_conv_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
  logic             err_hd;

  always #5 clk = ~clk;

  gray_conv_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_data  (out_data),
    .err_hd    (err_hd)
  );

  typedef struct {
    logic             mode;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;
  bit               lat_chk = 1'b0;
  bit               ovr_en = 1'b0;
  logic [WIDTH-1:0] ovr_val = '0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_mode = 1'b0;
  logic             err_model = 1'b0;
  logic             have_gray = 1'b0;
  logic [WIDTH-1:0] last_gray = '0;

  // Each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] g2bRef(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < WIDTH; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2gRef(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Drive one cycle of inputs, then account for the transfers the next edge will perform.
  task automatic applyStimulus(input logic v, input logic m, input logic [WIDTH-1:0] d, input logic r);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_mode   = m;
    in_data   = d;
    out_ready = r;
    #1;
    cyc++;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (r || sb.size() < STAGES)});
    checkOutput("err_hd", {31'd0, err_hd}, {31'd0, err_model});
    if (prev_stall) begin
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_data", {24'd0, out_data}, {24'd0, prev_data});
      checkOutput("stall_mode", {31'd0, out_mode}, {31'd0, prev_mode});
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("out_data", {24'd0, out_data}, {24'd0, e.data});
        checkOutput("out_mode", {31'd0, out_mode}, {31'd0, e.mode});
        if (lat_chk) checkOutput("latency", cyc - e.cyc, STAGES);
      end
    end
    if (in_valid && in_ready) begin
      e.mode = m;
      e.data = ovr_en ? ovr_val : (m ? b2gRef(d) : g2bRef(d));
      e.cyc  = cyc;
      sb.push_back(e);
`ifdef GRAY_CONV_HD_CHK_EN
      if (!m) begin
        if (have_gray && $countones(d ^ last_gray) > 1) err_model = 1'b1;
        last_gray = d;
        have_gray = 1'b1;
      end
`endif
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_mode  = out_mode;
  endtask

  task automatic directed(input logic m, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    ovr_en  = 1'b1;
    ovr_val = exp;
    applyStimulus(1'b1, m, d, 1'b1);
    ovr_en  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_out_mode", {31'd0, out_mode}, 32'd0);
    checkOutput("rst_err_hd", {31'd0, err_hd}, 32'd0);
    sb.delete();
    err_model  = 1'b0;
    have_gray  = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();
    lat_chk = 1'b1;

    directed(1'b0, 8'hC3, 8'h82);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    directed(1'b1, 8'h82, 8'hC3);
    directed(1'b0, 8'h80, 8'hFF);
    drain();

    for (int i = 0; i < 256; i++) applyStimulus(1'b1, i[0], i[7:0], 1'b1);
    drain();

    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    drain();

    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] Hamming-distance sequence");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h01, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hF0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h03, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    drain();
    doReset();

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(0, 3) != 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
